// File: rtl/proj_min_tracker.sv
// proj_min_tracker
//   Tracks the minimum hash word, and the index where it first occurred,
//   over one FM buffer pass (index 0..FM_BUFFER_SIZE-1). When the pass
//   ends, the result goes into a valid/ready output register for the
//   signature stage.
//
// Optional feature, enabled by the macro PROJ_MINTRACK_ARGMAX_EN:
//   the block also tracks the maximum hash and its index, and presents
//   them on max_hash/max_index alongside min_hash/min_index.
//
// Ports:
//   clk, rst_n         clock; asynchronous active-low reset
//   in_valid           hash_in/index_in are valid this cycle
//   hash_in            hash word read at index_in
//   index_in           current buffer index from the index counter
//   finished_count     counter end-of-pass flag, high with the last index
//   out_valid          result register holds an unconsumed result
//   out_ready          consumer accepts the result
//   min_hash/min_index minimum of the completed pass and its index
//   max_hash/max_index (optional) maximum of the completed pass and its index
//   overrun            one-cycle pulse: a completed pass was dropped
module proj_min_tracker #(
  parameter int FM_BUFFER_SIZE = 8,
  parameter int HASH_W         = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  input  logic [HASH_W-1:0]         hash_in,
  input  logic [FM_BUFFER_SIZE-1:0] index_in,
  input  logic                      finished_count,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [HASH_W-1:0]         min_hash,
  output logic [FM_BUFFER_SIZE-1:0] min_index,
`ifdef PROJ_MINTRACK_ARGMAX_EN
  output logic [HASH_W-1:0]         max_hash,
  output logic [FM_BUFFER_SIZE-1:0] max_index,
`endif
  output logic                      overrun
);

  typedef enum logic {SYNC = 1'b0, ACCUM = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [HASH_W-1:0]         acc_min_hash_q, acc_min_hash_d;
  logic [FM_BUFFER_SIZE-1:0] acc_min_idx_q, acc_min_idx_d;
  logic                      out_valid_q, out_valid_d;
  logic [HASH_W-1:0]         res_min_hash_q, res_min_hash_d;
  logic [FM_BUFFER_SIZE-1:0] res_min_idx_q, res_min_idx_d;
  logic                      overrun_q, overrun_d;

  logic                      pass_start;
  logic                      sample_take;
  logic                      complete;
  logic                      load_result;
  logic [HASH_W-1:0]         cand_min_hash;
  logic [FM_BUFFER_SIZE-1:0] cand_min_idx;

`ifdef PROJ_MINTRACK_ARGMAX_EN
  logic [HASH_W-1:0]         acc_max_hash_q, acc_max_hash_d;
  logic [FM_BUFFER_SIZE-1:0] acc_max_idx_q, acc_max_idx_d;
  logic [HASH_W-1:0]         res_max_hash_q, res_max_hash_d;
  logic [FM_BUFFER_SIZE-1:0] res_max_idx_q, res_max_idx_d;
  logic [HASH_W-1:0]         cand_max_hash;
  logic [FM_BUFFER_SIZE-1:0] cand_max_idx;
`endif

  assign pass_start = (index_in == '0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A pass that both starts and ends on the same sample
  // (single-entry buffer) never leaves SYNC.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SYNC:    if (in_valid && pass_start && !finished_count) state_d = ACCUM;
      ACCUM:   if (in_valid && finished_count)                state_d = SYNC;
      default: state_d = SYNC;
    endcase
  end

  // Datapath / output logic
  always_comb begin
    // In SYNC only an index-0 sample is accepted; in ACCUM every valid one.
    sample_take = in_valid && ((state_q == ACCUM) || pass_start);
    complete    = sample_take && finished_count;

    // Index 0 always restarts the pass; otherwise strict compare so that
    // ties keep the earlier index.
    cand_min_hash = acc_min_hash_q;
    cand_min_idx  = acc_min_idx_q;
    if (pass_start) begin
      cand_min_hash = hash_in;
      cand_min_idx  = '0;
    end else if (hash_in < acc_min_hash_q) begin
      cand_min_hash = hash_in;
      cand_min_idx  = index_in;
    end

    acc_min_hash_d = sample_take ? cand_min_hash : acc_min_hash_q;
    acc_min_idx_d  = sample_take ? cand_min_idx  : acc_min_idx_q;

    // Accepting and reloading in the same cycle keeps out_valid high.
    load_result    = complete && (!out_valid_q || out_ready);
    out_valid_d    = load_result ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    res_min_hash_d = load_result ? cand_min_hash : res_min_hash_q;
    res_min_idx_d  = load_result ? cand_min_idx  : res_min_idx_q;
    // A completion that cannot be stored is dropped; the held result wins.
    overrun_d      = complete && out_valid_q && !out_ready;

`ifdef PROJ_MINTRACK_ARGMAX_EN
    cand_max_hash = acc_max_hash_q;
    cand_max_idx  = acc_max_idx_q;
    if (pass_start) begin
      cand_max_hash = hash_in;
      cand_max_idx  = '0;
    end else if (hash_in > acc_max_hash_q) begin
      cand_max_hash = hash_in;
      cand_max_idx  = index_in;
    end
    acc_max_hash_d = sample_take ? cand_max_hash : acc_max_hash_q;
    acc_max_idx_d  = sample_take ? cand_max_idx  : acc_max_idx_q;
    res_max_hash_d = load_result ? cand_max_hash : res_max_hash_q;
    res_max_idx_d  = load_result ? cand_max_idx  : res_max_idx_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_min_hash_q <= '0;
      acc_min_idx_q  <= '0;
      out_valid_q    <= 1'b0;
      res_min_hash_q <= '0;
      res_min_idx_q  <= '0;
      overrun_q      <= 1'b0;
    end else begin
      acc_min_hash_q <= acc_min_hash_d;
      acc_min_idx_q  <= acc_min_idx_d;
      out_valid_q    <= out_valid_d;
      res_min_hash_q <= res_min_hash_d;
      res_min_idx_q  <= res_min_idx_d;
      overrun_q      <= overrun_d;
    end
  end

`ifdef PROJ_MINTRACK_ARGMAX_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_max_hash_q <= '0;
      acc_max_idx_q  <= '0;
      res_max_hash_q <= '0;
      res_max_idx_q  <= '0;
    end else begin
      acc_max_hash_q <= acc_max_hash_d;
      acc_max_idx_q  <= acc_max_idx_d;
      res_max_hash_q <= res_max_hash_d;
      res_max_idx_q  <= res_max_idx_d;
    end
  end

  assign max_hash  = res_max_hash_q;
  assign max_index = res_max_idx_q;
`endif

  assign out_valid = out_valid_q;
  assign min_hash  = res_min_hash_q;
  assign min_index = res_min_idx_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_proj_min_tracker.sv
module tb_proj_min_tracker;
  localparam int N  = 8;
  localparam int HW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [HW-1:0] hash_in;
  logic [N-1:0]  index_in;
  logic          finished_count;
  logic          out_valid;
  logic          out_ready;
  logic [HW-1:0] min_hash;
  logic [N-1:0]  min_index;
  logic          overrun;
`ifdef PROJ_MINTRACK_ARGMAX_EN
  logic [HW-1:0] max_hash;
  logic [N-1:0]  max_index;
`endif

  always #5 clk = ~clk;

  proj_min_tracker #(.FM_BUFFER_SIZE(N), .HASH_W(HW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .hash_in        (hash_in),
    .index_in       (index_in),
    .finished_count (finished_count),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .min_hash       (min_hash),
    .min_index      (min_index),
`ifdef PROJ_MINTRACK_ARGMAX_EN
    .max_hash       (max_hash),
    .max_index      (max_index),
`endif
    .overrun        (overrun)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: the samples of the pass in progress are kept as a list;
  // at pass end the arg-min/arg-max is found by scanning that list.
  bit            m_in_pass;
  int            q_h[$];
  int            q_i[$];
  logic          m_valid;
  logic [HW-1:0] m_min;
  logic [N-1:0]  m_idx;
  logic [HW-1:0] m_max;
  logic [N-1:0]  m_maxi;
  logic          m_ovr;

  task automatic model_reset();
    m_in_pass = 0;
    q_h.delete();
    q_i.delete();
    m_valid = 0; m_min = '0; m_idx = '0; m_max = '0; m_maxi = '0; m_ovr = 0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input logic v, input int h, input int idx, input logic fin, input logic rdy);
    bit done;
    bit ovr;
    int bh, bi, xh, xi;
    in_valid       = v;
    hash_in        = h[HW-1:0];
    index_in       = idx[N-1:0];
    finished_count = fin;
    out_ready      = rdy;
    @(posedge clk);
    done = 0; ovr = 0; bh = 0; bi = 0; xh = 0; xi = 0;
    if (v) begin
      if (idx == 0) begin
        q_h.delete(); q_i.delete(); m_in_pass = 1;
      end
      if (m_in_pass) begin
        q_h.push_back(h); q_i.push_back(idx);
      end
      if (fin && m_in_pass) begin
        bh = q_h[0]; bi = q_i[0]; xh = q_h[0]; xi = q_i[0];
        foreach (q_h[k]) begin
          if (q_h[k] < bh) begin bh = q_h[k]; bi = q_i[k]; end
          if (q_h[k] > xh) begin xh = q_h[k]; xi = q_i[k]; end
        end
        done = 1; m_in_pass = 0;
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_valid = 1; m_min = bh[HW-1:0]; m_idx = bi[N-1:0];
        m_max = xh[HW-1:0]; m_maxi = xi[N-1:0];
        $display("pass result: min=%0d at %0d max=%0d at %0d", bh, bi, xh, xi);
      end else begin
        ovr = 1;
        $display("pass dropped (result register full): min=%0d at %0d", bh, bi);
      end
    end else if (rdy) begin
      m_valid = 0;
    end
    m_ovr = ovr;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0; in_valid = 0; hash_in = '0; index_in = '0; finished_count = 0; out_ready = 0;
    model_reset();
    #12;
    n_checks++;
    if ({out_valid, min_hash, min_index, overrun} !== '0)
      $display("FAIL reset_state: got v=%b h=%0d i=%0d o=%b, expected all 0", out_valid, min_hash, min_index, overrun);
    else n_pass++;
    #1 rst_n = 1;
  endtask

  task automatic test_basic();
    int hs[8];
    hs = '{50, 40, 30, 20, 10, 60, 70, 80};
    for (int i = 0; i < 8; i++) step(1, hs[i], i, i == 7, 1);
    n_checks++;
    if ({out_valid, min_hash, min_index} !== {1'b1, 16'd10, 8'd4})
      $display("FAIL basic_result: got v=%b h=%0d i=%0d, expected v=1 h=10 i=4", out_valid, min_hash, min_index);
    else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL basic_clear: got v=%b, expected v=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_tie();
    int hs[8];
    hs = '{9, 5, 7, 5, 8, 6, 5, 9};
    for (int i = 0; i < 8; i++) step(1, hs[i], i, i == 7, 1);
    n_checks++;
    if ({out_valid, min_hash, min_index} !== {1'b1, 16'd5, 8'd1})
      $display("FAIL tie_result: got v=%b h=%0d i=%0d, expected v=1 h=5 i=1", out_valid, min_hash, min_index);
    else n_pass++;
`ifdef PROJ_MINTRACK_ARGMAX_EN
    n_checks++;
    if ({max_hash, max_index} !== {16'd9, 8'd0})
      $display("FAIL tie_max: got h=%0d i=%0d, expected h=9 i=0", max_hash, max_index);
    else n_pass++;
`endif
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_back_to_back_overrun();
    int p1[8];
    int p2[8];
    p1 = '{9, 8, 3, 7, 6, 5, 4, 8};
    p2 = '{5, 4, 3, 2, 1, 6, 7, 8};
    for (int i = 0; i < 8; i++) step(1, p1[i], i, i == 7, 0);
    for (int i = 0; i < 8; i++) begin
      step(1, p2[i], i, i == 7, 0);
      n_checks++;
      if ({out_valid, min_hash, min_index, overrun} !== {1'b1, 16'd3, 8'd2, (i == 7)})
        $display("FAIL overrun_hold idx%0d: got v=%b h=%0d i=%0d o=%b, expected v=1 h=3 i=2 o=%0d",
                 i, out_valid, min_hash, min_index, overrun, i == 7);
      else n_pass++;
    end
    step(0, 0, 0, 0, 0);
    n_checks++;
    if ({out_valid, min_hash, overrun} !== {1'b1, 16'd3, 1'b0})
      $display("FAIL overrun_pulse_end: got v=%b h=%0d o=%b, expected v=1 h=3 o=0", out_valid, min_hash, overrun);
    else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL overrun_drain: got v=%b, expected v=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_sync_after_reset();
    int hs[8];
    hs = '{100, 90, 80, 70, 60, 50, 22, 40};
    rst_n = 0; in_valid = 1; hash_in = '0; index_in = 8'd5; finished_count = 0;
    model_reset();
    #2 rst_n = 1;
    for (int i = 5; i < 8; i++) step(1, 0, i, i == 7, 1);
    step(0, 0, 0, 0, 1);
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL sync_partial_ignored: got v=%b, expected v=0", out_valid);
    else n_pass++;
    for (int i = 0; i < 8; i++) step(1, hs[i], i, i == 7, 1);
    n_checks++;
    if ({out_valid, min_hash, min_index} !== {1'b1, 16'd22, 8'd6})
      $display("FAIL sync_result: got v=%b h=%0d i=%0d, expected v=1 h=22 i=6", out_valid, min_hash, min_index);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    // Hold a result (out_ready=0) so the asynchronous clear is observable.
    for (int i = 0; i < 8; i++) step(1, 30 + i, i, i == 7, 0);
    for (int i = 0; i < 4; i++) step(1, 7 - i, i, 0, 0);
    #2 rst_n = 0;
    #1;
    n_checks++;
    if ({out_valid, min_hash, min_index, overrun} !== '0)
      $display("FAIL async_reset: got v=%b h=%0d i=%0d o=%b, expected all 0", out_valid, min_hash, min_index, overrun);
    else n_pass++;
    model_reset();
    #1 rst_n = 1;
    for (int i = 4; i < 8; i++) step(1, 1, i, i == 7, 1);
    n_checks++;
    if (out_valid !== 1'b0)
      $display("FAIL async_reset_no_result: got v=%b, expected v=0", out_valid);
    else n_pass++;
  endtask

  task automatic test_gaps();
    int hs[8];
    hs = '{50, 40, 30, 20, 10, 60, 70, 80};
    for (int i = 0; i < 8; i++) begin
      // Gap cycles carry junk, including a stray end-of-pass flag.
      if (i == 2) step(0, 1, 2, 0, 1);
      if (i == 5) step(0, 2, 5, 1, 1);
      step(1, hs[i], i, i == 7, 1);
    end
    n_checks++;
    if ({out_valid, min_hash, min_index} !== {1'b1, 16'd10, 8'd4})
      $display("FAIL gaps_result: got v=%b h=%0d i=%0d, expected v=1 h=10 i=4", out_valid, min_hash, min_index);
    else n_pass++;
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_random();
    int cnt = 0;
    bit v;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 19) == 0) cnt = $urandom_range(0, N - 1);
      v = ($urandom_range(0, 3) != 0);
      step(v, $urandom_range(0, 15), cnt, cnt == N - 1, $urandom_range(0, 1) == 1);
      if (v) cnt = (cnt + 1) % N;
      n_checks++;
      if ({out_valid, min_hash, min_index, overrun} !== {m_valid, m_min, m_idx, m_ovr})
        $display("FAIL random cyc%0d: got v=%b h=%0d i=%0d o=%b, expected v=%b h=%0d i=%0d o=%b",
                 c, out_valid, min_hash, min_index, overrun, m_valid, m_min, m_idx, m_ovr);
      else n_pass++;
`ifdef PROJ_MINTRACK_ARGMAX_EN
      n_checks++;
      if ({max_hash, max_index} !== {m_max, m_maxi})
        $display("FAIL random_max cyc%0d: got h=%0d i=%0d, expected h=%0d i=%0d",
                 c, max_hash, max_index, m_max, m_maxi);
      else n_pass++;
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tie();
    test_back_to_back_overrun();
    test_sync_after_reset();
    test_async_reset();
    test_gaps();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/proj_min_tracker.md
Name: proj_min_tracker

Overview:
- Downstream neighbour of the FM buffer index counter.
- Each cycle it takes one hash word read from the FM buffer at the counter's current index, plus the counter's end-of-pass flag.
- Over one full pass (index 0..FM_BUFFER_SIZE-1) it tracks the minimum hash and the index where it occurred.
- At pass end it presents {min_hash, min_index} on a valid/ready output register for the signature stage.

Parameters:
- FM_BUFFER_SIZE, 8, entries per FM buffer pass; also the width of the index bus (matches the counter).
- HASH_W, 32, width of each hash word.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- in_valid  input  1  hash_in/index_in are valid this cycle
- hash_in  input  HASH_W  hash word at index_in
- index_in  input  FM_BUFFER_SIZE  current buffer index from the counter
- finished_count  input  1  counter end-of-pass flag; high with the last index (FM_BUFFER_SIZE-1)
- out_valid  output  1  result register holds an unconsumed result
- out_ready  input  1  consumer accepts the result
- min_hash  output  HASH_W  minimum hash of the completed pass
- min_index  output  FM_BUFFER_SIZE  index of that minimum
- overrun  output  1  one-cycle pulse: a completed pass was dropped

Behaviour:
- Reset (async assert, sync release): state=SYNC; out_valid=0, min_hash=0, min_index=0, overrun=0; accumulator cleared. Assertion mid-pass discards the partial pass immediately.
- States: SYNC, ACCUM.
  - SYNC: wait for the start of a pass. Samples with in_valid=1 and index_in!=0 are ignored. in_valid=1 with index_in==0 loads the accumulator from {hash_in, 0} and moves to ACCUM.
  - ACCUM: each in_valid=1 sample compares against the accumulator.
    - Strict less-than: hash_in < acc_hash replaces both acc_hash and acc_index.
    - Ties keep the earlier index.
  - index_in==0 while in ACCUM: force-reload the accumulator (restart the pass); stay in ACCUM.
  - in_valid=1 with finished_count=1: the pass completes. The final min includes this sample. State returns to SYNC.
    - Next index 0 arrives the following cycle, so SYNC reloads back-to-back with no lost sample.
- in_valid=0 cycles: accumulator holds; finished_count is ignored when in_valid=0.
- Comparison is unsigned, full HASH_W; no arithmetic, no width growth.
- Output register:
  - Latency: result appears with out_valid=1 one cycle after the completing sample.
  - min_hash/min_index are stable while out_valid=1 and out_ready=0.
  - Handshake: transfer on out_valid & out_ready. out_valid clears next cycle unless a new result loads in that same cycle.
  - Simultaneous accept and new completion: the new result loads and out_valid stays 1 (no bubble).
  - New completion while out_valid=1 and out_ready=0: new result is dropped, old result is kept, and overrun pulses high for one cycle.
- FM_BUFFER_SIZE=1: every valid sample is both index 0 and finished; result = that sample.

Optional Feature:
- Macro: PROJ_MINTRACK_ARGMAX_EN
- Defined:
  - Also tracks the maximum hash and its index, with the same tie rule (keep the earlier index).
  - Adds outputs max_hash [HASH_W] and max_index [FM_BUFFER_SIZE], loaded and handshaken together with min_hash/min_index.
  - Reset values are 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan (FM_BUFFER_SIZE=8, HASH_W=16):
- Pass hashes 50,40,30,20,10,60,70,80 with index 0..7, finished_count at index 7, out_ready=1 -> one cycle after index 7: out_valid=1, min_hash=10, min_index=4; out_valid=0 the following cycle.
- Tie: hashes 9,5,7,5,8,6,5,9 -> min_hash=5, min_index=1.
- Back-to-back passes with out_ready held 0, first pass min 3, second pass min 1 -> first result holds (min_hash=3); overrun=1 for exactly one cycle one cycle after the second pass's index 7; out_valid stays 1.
- Sequence:
  - Reset released while index_in=5.
  - Indices 5,6,7 with hashes 0,0,0 -> ignored (SYNC).
  - Next pass with min 22 at index 6 -> min_hash=22, min_index=6; no result produced for the partial pass.
- rst_n asserted at index 3 of a pass -> out_valid, min_hash, min_index drop to 0 asynchronously; no result emitted for that pass.
- in_valid=0 gaps inserted at indices 2 and 5 (index held) -> same result as the gap-free run of test 1.
